wb_regfile: RTL
===============

Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline buffer: the write-back stage plus the 32x32 general register file.
- Takes the registered write-back control bits (RegWrite, MemToReg), the memory read data, the ALU result and the destination register number.
- Selects the write-back value, commits it to the register file and serves the two ID-stage read ports.
- Keeps a saturating count of committed writes for the debug path.

Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 5, register number width (2**ADDR_W registers)
- CNT_W, 16, width of the committed-write counter

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_regw  input  1  RegWrite from MEM/WB buffer (WB[1])
- wb_memtoreg  input  1  MemToReg from MEM/WB buffer (WB[0]); 1 selects memory data
- wb_memdata  input  DATA_W  load data from MEM/WB buffer
- wb_alures  input  DATA_W  ALU result from MEM/WB buffer
- wb_rd  input  ADDR_W  destination register number
- rs_addr  input  ADDR_W  read port A register number (ID stage)
- rt_addr  input  ADDR_W  read port B register number (ID stage)
- rs_data  output  DATA_W  read port A data, combinational
- rt_data  output  DATA_W  read port B data, combinational
- wb_data  output  DATA_W  selected write-back value, combinational, for EX forwarding
- wb_cnt  output  CNT_W  number of committed register writes, saturating

Behaviour:
- Reset (rst_n low, asynchronous):
  - all registers 0..31 cleared to 0
  - wb_cnt = 0
  - rs_data, rt_data and wb_data follow from the cleared state and current inputs; none is held.
- Write-back select: wb_data = wb_memtoreg ? wb_memdata : wb_alures. No latency, always driven, including when wb_regw = 0.
- Commit condition: wb_regw = 1 and wb_rd != 0.
  - On the rising edge, register[wb_rd] <= wb_data.
  - Single write port; one commit per cycle at most.
- Register 0: hardwired zero.
  - Writes to r0 are discarded.
  - Reads of r0 always return 0, bypass included.
- Reads: rs_data = register[rs_addr], rt_data = register[rt_addr], combinational. Reading the same register on both ports is legal.
- Counter:
  - wb_cnt increments by 1 on each commit edge.
  - At 2**CNT_W-1 it saturates and holds; it does not wrap.
  - Writes to r0 do not count.
- Reset mid-operation: asynchronous clear wins over any commit on the same edge. The first commit is possible on the first rising edge after rst_n deasserts.
- Unknown or X on wb_regw is treated as no write; the simulation check flags it.
- State machine: none beyond register storage and the counter. The block is a pure sink of the MEM/WB interface and has no backpressure.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN
- Defined: write-first bypass. When the commit condition holds and rs_addr == wb_rd (non-zero), rs_data = wb_data in the same cycle. rt_data behaves the same way. ID therefore sees a value written back in the same cycle, with no extra stall.
- Undefined: reads return stored contents only. A same-cycle read returns the old value, and the hazard unit must stall one cycle.

Decomposition:
- Shared package (pipeline defs) holds:
  - REG_ZERO constant (5'd0)
  - DATA_W/ADDR_W defaults
  - WB field indices: WB_REGW = 1, WB_MEMTOREG = 0, shared with the MEM/WB buffer so both ends agree on the WB bit order.
- One natural sub-module: wb_mux, the 2:1 write-back select, reusable by the forwarding unit. Storage, bypass and counter stay in the top block.

Test Plan:
- Reset state: rst_n = 0 for 2 cycles, then release -> every register reads 0, wb_cnt = 0, and reading r31 on rs returns 0.
- ALU write: wb_regw = 1, wb_memtoreg = 0, wb_alures = 0xDEADBEEF, wb_rd = 5. Next cycle rs_addr = 5 -> rs_data = 0xDEADBEEF and wb_cnt = 1.
- Load write: wb_memtoreg = 1, wb_memdata = 0x12345678, wb_alures = 0xFFFFFFFF, wb_rd = 7 -> wb_data = 0x12345678 in the same cycle; rt_addr = 7 returns 0x12345678 after the edge.
- r0 protection: wb_regw = 1, wb_rd = 0, wb_alures = 0xAAAA5555 -> rs_addr = 0 reads 0 and wb_cnt is unchanged.
- Same-cycle read/write: register 9 holds 0x1, then commit 0x2 to register 9 with rs_addr = 9 in the same cycle -> rs_data = 0x2 with WB_REGFILE_BYPASS_EN, rs_data = 0x1 without it.
- Async reset mid-stream: back-to-back commits to r1..r4, assert rst_n low between edges -> all registers 0 immediately, and no commit on the coincident edge. Separately, force wb_cnt to 0xFFFF, commit once more -> wb_cnt stays at 0xFFFF.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Pipeline definitions shared by the MEM/WB buffer, write-back stage and forwarding unit.
// Constants only: no latency, no flow control.
// WB field indices fix the bit order of the 2-bit WB control bundle for both ends.
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int WB_W        = 2;
    localparam int WB_REGW     = 1;
    localparam int WB_MEMTOREG = 0;

    typedef logic [WB_W-1:0] wb_ctrl_t;

endpackage

// File: rtl/wb_mux.sv
// Write-back 2:1 select between load data and ALU result.
// Latency: combinational, zero cycles.
// Backpressure: none, output always driven.
module wb_mux
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              memtoreg,
    input  logic [DATA_W-1:0] memdata,
    input  logic [DATA_W-1:0] alures,
    output logic [DATA_W-1:0] data
);

    assign data = memtoreg ? memdata : alures;

endmodule

// File: rtl/wb_regfile.sv
// Write-back stage plus 2**ADDR_W x DATA_W register file, r0 hardwired to zero, saturating commit counter.
// Latency: writes commit on the rising edge; reads and wb_data are combinational.
// Backpressure: none, pure sink of MEM/WB. WB_REGFILE_BYPASS_EN enables write-first read bypass.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_regw,
    input  logic              wb_memtoreg,
    input  logic [DATA_W-1:0] wb_memdata,
    input  logic [DATA_W-1:0] wb_alures,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] wb_data,
    output logic [CNT_W-1:0]  wb_cnt
);

    localparam int NREG = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] RZ = ADDR_W'(REG_ZERO);

    wb_ctrl_t          wb_ctrl;
    logic              commit;
    logic [DATA_W-1:0] regs [NREG];

    always_comb begin
        wb_ctrl              = '0;
        wb_ctrl[WB_REGW]     = wb_regw;
        wb_ctrl[WB_MEMTOREG] = wb_memtoreg;
    end

    wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
        .memtoreg (wb_ctrl[WB_MEMTOREG]),
        .memdata  (wb_memdata),
        .alures   (wb_alures),
        .data     (wb_data)
    );

    // An X on RegWrite evaluates false here, so it never commits.
    assign commit = (wb_ctrl[WB_REGW] == 1'b1) && (wb_rd != RZ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit) begin
            regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_cnt <= '0;
        end else if (commit && (wb_cnt != {CNT_W{1'b1}})) begin
            wb_cnt <= wb_cnt + 1'b1;
        end
    end

    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != RZ) begin
            rs_data = regs[rs_addr];
        end
        if (rt_addr != RZ) begin
            rt_data = regs[rt_addr];
        end
`ifdef WB_REGFILE_BYPASS_EN
        // Write-first: ID sees the value being committed this cycle.
        if (commit && (rs_addr == wb_rd)) begin
            rs_data = wb_data;
        end
        if (commit && (rt_addr == wb_rd)) begin
            rt_data = wb_data;
        end
`endif
    end

`ifndef SYNTHESIS
    a_regw_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(wb_regw));
`endif

endmodule
